// File: rtl/pipe_pkg.sv
// Shared types and parameter limits for the pipeline segment register.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        FULL  = 2'b01,
        SKID  = 2'b10
    } pipe_state_t;

    localparam int unsigned MinDataW = 1;
    localparam int unsigned MinCntW  = 1;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts cycles with inc high, holds at all-ones, cleared only by reset.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline segment register with valid/ready handshake, flush and stall counter.
// Define PIPE_STAGE_REG_SKID_EN for a two-entry skid variant with a registered in_ready.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W         = 32,
    parameter bit          CLEAR_ON_FLUSH = 1'b1,
    parameter int unsigned CNT_W          = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cycles
);

    if (DATA_W < MinDataW || CNT_W < MinCntW) begin : g_param_check
        $error("pipe_stage_reg: DATA_W and CNT_W must be at least 1");
    end

    pipe_state_t       state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              in_fire, out_fire;

    assign out_valid = (state_q != EMPTY);
    assign out_data  = data_q;
    assign out_fire  = out_valid && out_ready;
    assign in_fire   = in_valid && in_ready;

`ifdef PIPE_STAGE_REG_SKID_EN
    logic [DATA_W-1:0] skid_q, skid_d;

    // Ready depends only on state flops, so upstream never sees out_ready combinationally.
    assign in_ready = (state_q != SKID);

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
            if (CLEAR_ON_FLUSH) begin
                data_d = '0;
                skid_d = '0;
            end
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d = FULL;
                        data_d  = in_data;
                    end
                end
                FULL: begin
                    if (in_fire && out_fire) begin
                        data_d = in_data;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end else if (in_fire) begin
                        state_d = SKID;
                        skid_d  = in_data;
                    end
                end
                SKID: begin
                    if (out_fire) begin
                        state_d = FULL;
                        data_d  = skid_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            skid_q <= '0;
        end else begin
            skid_q <= skid_d;
        end
    end
`else
    assign in_ready = !out_valid || out_ready;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        if (flush) begin
            state_d = EMPTY;
            if (CLEAR_ON_FLUSH) begin
                data_d = '0;
            end
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d = FULL;
                        data_d  = in_data;
                    end
                end
                FULL: begin
                    // Input can only fire here alongside an output fire.
                    if (out_fire) begin
                        if (in_fire) begin
                            data_d = in_data;
                        end else begin
                            state_d = EMPTY;
                        end
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .resetn(resetn),
        .inc   (out_valid && !out_ready),
        .count (stall_cycles)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: two instances (clear/keep on flush) checked against a queue model.
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        resetn, flush, in_valid, out_ready;
    logic [31:0] in_data;

    logic        in_ready_a, in_ready_b, out_valid_a, out_valid_b;
    logic [31:0] out_data_a, out_data_b;
    logic [2:0]  stall_a;
    logic [15:0] stall_b;
    logic [86:0] obs;

    always #5 clk = ~clk;

    pipe_stage_reg #(
        .DATA_W(32), .CLEAR_ON_FLUSH(1'b1), .CNT_W(3)
    ) dut_a (
        .clk(clk), .resetn(resetn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
        .stall_cycles(stall_a)
    );

    pipe_stage_reg #(
        .DATA_W(32), .CLEAR_ON_FLUSH(1'b0), .CNT_W(16)
    ) dut_b (
        .clk(clk), .resetn(resetn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
        .stall_cycles(stall_b)
    );

    assign obs = {out_valid_a, out_valid_b, in_ready_a, in_ready_b,
                  out_data_a, out_data_b, stall_a, stall_b};

    // Reference model: FIFO of held payloads plus the last value shown on out_data.
    logic [31:0] q[$];
    logic [31:0] disp_a, disp_b;
    int unsigned cnt_a, cnt_b;
    int          n_checks = 0;
    int          n_pass   = 0;

    function automatic bit m_in_ready();
`ifdef PIPE_STAGE_REG_SKID_EN
        return q.size() < 2;
`else
        return (q.size() == 0) || out_ready;
`endif
    endfunction

    function automatic logic [86:0] exp_vec();
        logic v;
        logic r;
        v = (q.size() != 0);
        r = m_in_ready();
        return {v, v, r, r, disp_a, disp_b, 3'(cnt_a), 16'(cnt_b)};
    endfunction

    task automatic model_clear();
        q.delete();
        disp_a = '0;
        disp_b = '0;
        cnt_a  = 0;
        cnt_b  = 0;
    endtask

    // Advance the model by one clock using the current inputs, then move to posedge+1.
    task automatic tick();
        bit inf, outf;
        inf  = in_valid && m_in_ready();
        outf = (q.size() != 0) && out_ready;
        if (q.size() != 0 && !out_ready) begin
            cnt_a = (cnt_a < 7) ? cnt_a + 1 : 7;
            cnt_b = (cnt_b < 65535) ? cnt_b + 1 : 65535;
        end
        if (flush) begin
            q.delete();
            disp_a = '0;
        end else begin
            if (outf) void'(q.pop_front());
            if (inf) q.push_back(in_data);
            if (q.size() != 0) begin
                disp_a = q[0];
                disp_b = q[0];
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit iv, input logic [31:0] d, input bit ordy, input bit fl);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b1;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;
        model_clear();
        #1 resetn = 1'b0;
        #1;
        n_checks++;
        if (obs !== exp_vec()) $display("FAIL reset_initial: got %h want %h", obs, exp_vec());
        else n_pass++;
        release_reset();

        drive(1'b1, 32'h1234_5678, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        n_checks++;
        if (out_valid_a !== 1'b1 || out_data_a !== 32'h1234_5678 || stall_a !== 3'd1)
            $display("FAIL reset_hold_loaded: got v=%b d=%h s=%0d want v=1 d=12345678 s=1",
                     out_valid_a, out_data_a, stall_a);
        else n_pass++;

        #2 resetn = 1'b0;
        model_clear();
        #1;
        n_checks++;
        if (out_valid_a !== 1'b0 || out_data_a !== 32'h0 || stall_a !== 3'd0 ||
            out_valid_b !== 1'b0 || out_data_b !== 32'h0 || stall_b !== 16'd0)
            $display("FAIL reset_async: got %h want all outputs zero", obs);
        else n_pass++;
        n_checks++;
        if (obs !== exp_vec()) $display("FAIL reset_async_model: got %h want %h", obs, exp_vec());
        else n_pass++;
        release_reset();
    endtask

    task automatic test_streaming();
        for (int i = 1; i <= 16; i++) begin
            drive(1'b1, 32'(i), 1'b1, 1'b0);
            n_checks++;
            if (obs !== exp_vec())
                $display("FAIL stream_pre[%0d]: got %h want %h", i, obs, exp_vec());
            else n_pass++;
            tick();
            n_checks++;
            if (out_valid_a !== 1'b1 || out_data_a !== 32'(i))
                $display("FAIL stream_out[%0d]: got v=%b d=%h want v=1 d=%h",
                         i, out_valid_a, out_data_a, 32'(i));
            else n_pass++;
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        n_checks++;
        if (obs !== exp_vec()) $display("FAIL stream_drain: got %h want %h", obs, exp_vec());
        else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [31:0] got[$];
        bit          pending;
        drive(1'b1, 32'hA, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'hB, 1'b0, 1'b0);
        pending = !m_in_ready();
        tick();
        drive(pending, 32'hB, 1'b0, 1'b0);
        n_checks++;
        if (in_ready_a !== 1'b0 || out_valid_a !== 1'b1 || out_data_a !== 32'hA)
            $display("FAIL bp_held: got rdy=%b v=%b d=%h want rdy=0 v=1 d=0000000a",
                     in_ready_a, out_valid_a, out_data_a);
        else n_pass++;
        n_checks++;
        if (obs !== exp_vec()) $display("FAIL bp_held_model: got %h want %h", obs, exp_vec());
        else n_pass++;
        for (int c = 0; c < 6; c++) begin
            drive(pending, 32'hB, 1'b1, 1'b0);
            n_checks++;
            if (obs !== exp_vec())
                $display("FAIL bp_drain[%0d]: got %h want %h", c, obs, exp_vec());
            else n_pass++;
            if (out_valid_a && out_ready) got.push_back(out_data_a);
            if (pending && m_in_ready()) pending = 1'b0;
            tick();
        end
        n_checks++;
        if (got.size() != 2 || got[0] !== 32'hA || got[1] !== 32'hB)
            $display("FAIL bp_order: got %0d items %p want A then B", got.size(), got);
        else n_pass++;
    endtask

    task automatic test_flush();
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 32'hC + 32'(k), 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 32'hDEAD, 1'b0, 1'b1);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        n_checks++;
        if (out_valid_a !== 1'b0 || out_data_a !== 32'h0 ||
            out_valid_b !== 1'b0 || out_data_b !== 32'hC)
            $display("FAIL flush_held: got va=%b da=%h vb=%b db=%h want 0 0 0 0000000c",
                     out_valid_a, out_data_a, out_valid_b, out_data_b);
        else n_pass++;
        for (int c = 0; c < 3; c++) begin
            drive(1'b0, 32'h0, 1'b1, 1'b0);
            n_checks++;
            if (out_valid_a !== 1'b0 || out_valid_b !== 1'b0 || obs !== exp_vec())
                $display("FAIL flush_after[%0d]: got %h want %h", c, obs, exp_vec());
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_saturation();
        resetn = 1'b0;
        model_clear();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        release_reset();
        drive(1'b1, 32'h55, 1'b0, 1'b0);
        tick();
        for (int c = 0; c < 10; c++) begin
            drive(1'b0, 32'h0, 1'b0, 1'b0);
            tick();
        end
        n_checks++;
        if (stall_a !== 3'd7 || stall_b !== 16'd10)
            $display("FAIL sat_hold: got a=%0d b=%0d want a=7 b=10", stall_a, stall_b);
        else n_pass++;
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        n_checks++;
        if (stall_a !== 3'd7 || stall_b !== 16'd11 || out_valid_a !== 1'b0)
            $display("FAIL sat_flush: got a=%0d b=%0d v=%b want a=7 b=11 v=0",
                     stall_a, stall_b, out_valid_a);
        else n_pass++;
        n_checks++;
        if (obs !== exp_vec()) $display("FAIL sat_model: got %h want %h", obs, exp_vec());
        else n_pass++;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            drive(($urandom % 4) != 0, $urandom, ($urandom % 3) != 0, ($urandom % 20) == 0);
            n_checks++;
            if (obs !== exp_vec())
                $display("FAIL random[%0d]: got %h want %h", c, obs, exp_vec());
            else n_pass++;
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_saturation();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
